// File: rtl/eq_fixed_pkg.sv
// Shared Q-format constants and accumulator width helper for the
// equaliser fixed-point datapath.
package eq_fixed_pkg;

  localparam int Q_N     = 23;
  localparam int Q_DECIM = 14;
  localparam int Q_GUARD = 4;

  localparam int Q_MAX = (1 << (Q_N - 1)) - 1;
  localparam int Q_MIN = -Q_MAX;

  function automatic int acc_width(int n, int guard);
    return 2 * n + guard;
  endfunction

endpackage

// File: rtl/sat_round.sv
// ACC_W -> N conversion: optional half-up rounding (MULT_ACC_ROUND_EN),
// arithmetic shift by DECIM and symmetric saturation with clamp flag.
module sat_round
  import eq_fixed_pkg::*;
#(
  parameter int N     = Q_N,
  parameter int DECIM = Q_DECIM,
  parameter int ACC_W = acc_width(Q_N, Q_GUARD)
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic        [N-1:0]     data,
  output logic                    clamp
);

  localparam logic signed [ACC_W:0] OMAX =
    {{(ACC_W-N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN = -OMAX;

`ifdef MULT_ACC_ROUND_EN
  localparam logic signed [ACC_W:0] AMAX =
    {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] HALF =
    (ACC_W+1)'(1) << (DECIM - 1);
`endif

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] sh;

  always_comb begin
    ext = {acc[ACC_W-1], acc};
`ifdef MULT_ACC_ROUND_EN
    // the rounding add may not push past the accumulator range
    rnd = ext + HALF;
    if (rnd > AMAX)
      rnd = AMAX;
`else
    rnd = ext;
`endif
    sh    = rnd >>> DECIM;
    data  = sh[N-1:0];
    clamp = 1'b0;
    if (sh > OMAX) begin
      data  = OMAX[N-1:0];
      clamp = 1'b1;
    end else if (sh < OMIN) begin
      data  = OMIN[N-1:0];
      clamp = 1'b1;
    end
  end

endmodule

// File: rtl/mult_acc_sat.sv
// Pipelined signed MAC with per-channel saturating accumulators.
// Rounding mode selected by MULT_ACC_ROUND_EN (undefined: truncate).
module mult_acc_sat
  import eq_fixed_pkg::*;
#(
  parameter int N        = Q_N,
  parameter int DECIM    = Q_DECIM,
  parameter int CHANNELS = 2,
  parameter int GUARD    = Q_GUARD,
  localparam int CHW =
    (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [CHW-1:0] in_chan,
  input  logic           in_first,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic [CHW-1:0] out_chan,
  output logic           out_sat
);

  localparam int ACC_W = acc_width(N, GUARD);
  localparam logic [N-1:0] MOST_NEG =
    {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] NEG_LIM =
    {1'b1, {(N-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] AMAX =
    {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] AMIN = -AMAX;

  logic en;
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  logic signed [N-1:0] a_c;
  logic signed [N-1:0] b_c;
  assign a_c = (a == MOST_NEG) ? NEG_LIM : a;
  assign b_c = (b == MOST_NEG) ? NEG_LIM : b;

  logic                s1_v;
  logic signed [N-1:0] s1_a;
  logic signed [N-1:0] s1_b;
  logic [CHW-1:0]      s1_chan;
  logic                s1_first;
  logic                s1_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v     <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_chan  <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_v     <= in_valid;
      s1_a     <= a_c;
      s1_b     <= b_c;
      s1_chan  <= in_chan;
      s1_first <= in_first;
      s1_last  <= in_last;
    end
  end

  logic signed [2*N-1:0] a_x;
  logic signed [2*N-1:0] b_x;
  assign a_x = {{N{s1_a[N-1]}}, s1_a};
  assign b_x = {{N{s1_b[N-1]}}, s1_b};

  logic                  s2_v;
  logic signed [2*N-1:0] s2_p;
  logic [CHW-1:0]        s2_chan;
  logic                  s2_first;
  logic                  s2_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_v     <= 1'b0;
      s2_p     <= '0;
      s2_chan  <= '0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
    end else if (en) begin
      s2_v     <= s1_v;
      s2_p     <= a_x * b_x;
      s2_chan  <= s1_chan;
      s2_first <= s1_first;
      s2_last  <= s1_last;
    end
  end

  logic signed [ACC_W-1:0] acc [CHANNELS];
  logic [CHANNELS-1:0]     sticky;

  logic                    ch_ok;
  logic [CHW-1:0]          idx;
  logic signed [ACC_W-1:0] base;
  logic                    stk_in;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W-1:0] nxt;
  logic                    acc_clip;
  logic [N-1:0]            rdata;
  logic                    oclip;

  assign ch_ok = 32'(s2_chan) < CHANNELS;
  assign idx   = ch_ok ? s2_chan : '0;

  always_comb begin
    base     = s2_first ? '0 : acc[idx];
    stk_in   = s2_first ? 1'b0 : sticky[idx];
    sum      = {base[ACC_W-1], base}
             + {{(ACC_W+1-2*N){s2_p[2*N-1]}}, s2_p};
    nxt      = sum[ACC_W-1:0];
    acc_clip = 1'b0;
    if (sum > AMAX) begin
      nxt      = AMAX[ACC_W-1:0];
      acc_clip = 1'b1;
    end else if (sum < AMIN) begin
      nxt      = AMIN[ACC_W-1:0];
      acc_clip = 1'b1;
    end
  end

  sat_round #(
    .N     (N),
    .DECIM (DECIM),
    .ACC_W (ACC_W)
  ) u_sat_round (
    .acc   (nxt),
    .data  (rdata),
    .clamp (oclip)
  );

  // accumulator read-modify-write and result load share one edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++)
        acc[i] <= '0;
      sticky    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      out_sat   <= 1'b0;
    end else if (en) begin
      if (s2_v && ch_ok) begin
        acc[idx]    <= nxt;
        sticky[idx] <= stk_in | acc_clip;
      end
      if (s2_v && ch_ok && s2_last) begin
        out_valid <= 1'b1;
        out_data  <= rdata;
        out_chan  <= s2_chan;
        out_sat   <= oclip | stk_in | acc_clip;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
